// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: states, next-PC modes,
// ALU ops, opcode/funct constants and the instruction class seen by the FSM.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [2:0] NPC_PLUS4 = 3'b000;
   localparam logic [2:0] NPC_BEQ   = 3'b001;
   localparam logic [2:0] NPC_JUMP  = 3'b010;
   localparam logic [2:0] NPC_BNE   = 3'b011;
   localparam logic [2:0] NPC_JR    = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic [3:0] {
      C_RTYPE   = 4'd0,
      C_JR      = 4'd1,
      C_J       = 4'd2,
      C_LW      = 4'd3,
      C_SW      = 4'd4,
      C_BEQ     = 4'd5,
      C_BNE     = 4'd6,
      C_ADDI    = 4'd7,
      C_ORI     = 4'd8,
      C_ILLEGAL = 4'd9
   } inst_class_t;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       alu_src;
      logic       ext_zero;
   } alu_ctl_t;

   // ALU controls for an instruction class; R-type picks the op from funct.
   function automatic alu_ctl_t alu_ctl(inst_class_t cls, logic [5:0] funct);
      alu_ctl_t a;
      a = '{alu_op: ALU_ADD, alu_src: 1'b0, ext_zero: 1'b0};
      case (cls)
         C_RTYPE: begin
            case (funct)
               FN_SUB:  a.alu_op = ALU_SUB;
               FN_AND:  a.alu_op = ALU_AND;
               FN_OR:   a.alu_op = ALU_OR;
               FN_SLT:  a.alu_op = ALU_SLT;
               default: a.alu_op = ALU_ADD;
            endcase
         end
         C_ADDI: a.alu_src = 1'b1;
         C_ORI: begin
            a.alu_op   = ALU_OR;
            a.alu_src  = 1'b1;
            a.ext_zero = 1'b1;
         end
         C_LW, C_SW: a.alu_src = 1'b1;
         C_BEQ, C_BNE: a.alu_op = ALU_SUB;
         default: a.alu_op = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier: op/funct to the class the FSM sequences.
module mc_ctrl_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output inst_class_t cls
);

   // Map opcode (and funct for op 0) onto an instruction class.
   always_comb begin
      cls = C_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = C_RTYPE;
               FN_JR:                                 cls = C_JR;
               default:                               cls = C_ILLEGAL;
            endcase
         end
         OP_J:    cls = C_J;
         OP_BEQ:  cls = C_BEQ;
         OP_BNE:  cls = C_BNE;
         OP_ADDI: cls = C_ADDI;
         OP_ORI:  cls = C_ORI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         default: cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB, drives PC, register-file,
// ALU and data-memory controls, and counts retired instructions.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             ir_write,
   output logic             pc_write,
   output logic [2:0]       npc_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic             ext_zero,
   output logic [2:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             retire,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_cnt
);

   state_t      state_q;
   state_t      state_d;
   inst_class_t cls;
   alu_ctl_t    alu;

   mc_ctrl_dec u_dec (
      .op    (op),
      .funct (funct),
      .cls   (cls)
   );

   assign alu   = alu_ctl(cls, funct);
   assign state = state_q;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired_cnt <= '0;
      end else if (retire) begin
         retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end

   // Next state and per-state control outputs; everything held low under reset.
   always_comb begin
      state_d    = S_IF;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      npc_op     = NPC_PLUS4;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      ext_zero   = 1'b0;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      retire     = 1'b0;

      case (state_q)
         S_IF: begin
            ir_write = 1'b1;
            state_d  = S_ID;
         end

         S_ID: begin
            case (cls)
               C_J: begin
                  pc_write = 1'b1;
                  npc_op   = NPC_JUMP;
                  retire   = 1'b1;
                  state_d  = S_IF;
               end
               C_JR: begin
                  pc_write = 1'b1;
                  npc_op   = NPC_JR;
                  retire   = 1'b1;
                  state_d  = S_IF;
               end
               C_ILLEGAL: begin
                  // Skip the unsupported word without counting it.
                  illegal  = 1'b1;
                  pc_write = 1'b1;
                  npc_op   = NPC_PLUS4;
                  state_d  = S_IF;
               end
               default: state_d = S_EX;
            endcase
         end

         S_EX: begin
            alu_op   = alu.alu_op;
            alu_src  = alu.alu_src;
            ext_zero = alu.ext_zero;
            case (cls)
               C_BEQ: begin
                  pc_write = 1'b1;
                  npc_op   = NPC_BEQ;
                  retire   = 1'b1;
                  state_d  = S_IF;
               end
               C_BNE: begin
                  pc_write = 1'b1;
                  npc_op   = NPC_BNE;
                  retire   = 1'b1;
                  state_d  = S_IF;
               end
               C_LW, C_SW:             state_d = S_MEM;
               C_RTYPE, C_ADDI, C_ORI: state_d = S_WB;
               default:                state_d = S_IF;
            endcase
         end

         S_MEM: begin
            alu_op    = alu.alu_op;
            alu_src   = alu.alu_src;
            ext_zero  = alu.ext_zero;
            mem_read  = (cls == C_LW);
            mem_write = (cls == C_SW);
            if (!mem_ready) begin
               state_d = S_MEM;
            end else if (cls == C_SW) begin
               pc_write = 1'b1;
               npc_op   = NPC_PLUS4;
               retire   = 1'b1;
               state_d  = S_IF;
            end else if (cls == C_LW) begin
               state_d = S_WB;
            end else begin
               state_d = S_IF;
            end
         end

         S_WB: begin
            alu_op     = alu.alu_op;
            alu_src    = alu.alu_src;
            ext_zero   = alu.ext_zero;
            reg_write  = 1'b1;
            reg_dst    = (cls == C_RTYPE);
            mem_to_reg = (cls == C_LW);
            pc_write   = 1'b1;
            npc_op     = NPC_PLUS4;
            retire     = 1'b1;
            state_d    = S_IF;
         end

         default: state_d = S_IF;
      endcase

      if (rst) begin
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         npc_op     = NPC_PLUS4;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         alu_src    = 1'b0;
         ext_zero   = 1'b0;
         alu_op     = ALU_ADD;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         illegal    = 1'b0;
         retire     = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: random instruction stream against a per-instruction
// cycle-trace model; a monitor compares every cycle against the queued trace.
// A second 4-bit-counter instance shares the stimulus to exercise counter wrap.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       mem_ready = 1'b0;

   logic        ir_write, pc_write, reg_write, reg_dst, alu_src, ext_zero;
   logic        mem_read, mem_write, mem_to_reg, illegal, retire;
   logic [2:0]  npc_op, alu_op, state;
   logic [31:0] retired_cnt;

   logic        ir_write_s, pc_write_s, reg_write_s, reg_dst_s, alu_src_s, ext_zero_s;
   logic        mem_read_s, mem_write_s, mem_to_reg_s, illegal_s, retire_s;
   logic [2:0]  npc_op_s, alu_op_s, state_s;
   logic [3:0]  retired_cnt_s;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
      .ir_write(ir_write), .pc_write(pc_write), .npc_op(npc_op),
      .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
      .ext_zero(ext_zero), .alu_op(alu_op), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
      .retire(retire), .state(state), .retired_cnt(retired_cnt)
   );

   mc_ctrl #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
      .ir_write(ir_write_s), .pc_write(pc_write_s), .npc_op(npc_op_s),
      .reg_write(reg_write_s), .reg_dst(reg_dst_s), .alu_src(alu_src_s),
      .ext_zero(ext_zero_s), .alu_op(alu_op_s), .mem_read(mem_read_s),
      .mem_write(mem_write_s), .mem_to_reg(mem_to_reg_s), .illegal(illegal_s),
      .retire(retire_s), .state(state_s), .retired_cnt(retired_cnt_s)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       ir_write;
      logic       pc_write;
      logic [2:0] npc_op;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src;
      logic       ext_zero;
      logic [2:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       illegal;
      logic       retire;
   } ctl_t;

   typedef struct {
      ctl_t        c;
      logic [31:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] cnt_m = 32'd0;

   localparam int K_R = 0, K_JR = 1, K_J = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
   localparam int K_BNE = 6, K_ADDI = 7, K_ORI = 8, K_ILL = 9;

   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h00: begin
            if (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a) return K_R;
            if (f == 6'h08) return K_JR;
            return K_ILL;
         end
         6'h02: return K_J;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h08: return K_ADDI;
         6'h0d: return K_ORI;
         6'h23: return K_LW;
         6'h2b: return K_SW;
         default: return K_ILL;
      endcase
   endfunction

   // {alu_op, alu_src, ext_zero} for an instruction.
   function automatic logic [4:0] alu_of(input int k, input logic [5:0] f);
      case (k)
         K_R: begin
            case (f)
               6'h22:   return {3'd1, 1'b0, 1'b0};
               6'h24:   return {3'd2, 1'b0, 1'b0};
               6'h25:   return {3'd3, 1'b0, 1'b0};
               6'h2a:   return {3'd4, 1'b0, 1'b0};
               default: return {3'd0, 1'b0, 1'b0};
            endcase
         end
         K_ADDI, K_LW, K_SW: return {3'd0, 1'b1, 1'b0};
         K_ORI:              return {3'd3, 1'b1, 1'b1};
         K_BEQ, K_BNE:       return {3'd1, 1'b0, 1'b0};
         default:            return 5'd0;
      endcase
   endfunction

   function automatic ctl_t zc(input logic [2:0] st);
      ctl_t c;
      c = '0;
      c.st = st;
      return c;
   endfunction

   // One clock of stimulus plus the response expected during that clock.
   task automatic step(input logic r, input logic mr, input logic [5:0] o,
                       input logic [5:0] f, input ctl_t c);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      mem_ready = mr;
      op = o;
      funct = f;
      if (r) cnt_m = 32'd0;
      e.c = c;
      e.cnt = cnt_m;
      q.push_back(e);
      if (c.retire) cnt_m = cnt_m + 32'd1;
   endtask

   task automatic reset_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 6'd0, 6'd0, zc(3'd0));
   endtask

   // Issue one instruction; w extra memory wait cycles; abort resets mid-S_MEM.
   task automatic run_inst(input logic [5:0] o, input logic [5:0] f, input int w,
                           input bit abort);
      int   k;
      ctl_t c;
      k = classify(o, f);

      c = zc(3'd0);
      c.ir_write = 1'b1;
      step(1'b0, 1'($urandom), o, f, c);

      c = zc(3'd1);
      if (k == K_J || k == K_JR || k == K_ILL) begin
         c.pc_write = 1'b1;
         c.npc_op = (k == K_J) ? 3'b010 : (k == K_JR) ? 3'b100 : 3'b000;
         c.retire = (k != K_ILL);
         c.illegal = (k == K_ILL);
         step(1'b0, 1'($urandom), o, f, c);
         return;
      end
      step(1'b0, 1'($urandom), o, f, c);

      c = zc(3'd2);
      {c.alu_op, c.alu_src, c.ext_zero} = alu_of(k, f);
      if (k == K_BEQ || k == K_BNE) begin
         c.pc_write = 1'b1;
         c.npc_op = (k == K_BEQ) ? 3'b001 : 3'b011;
         c.retire = 1'b1;
         step(1'b0, 1'($urandom), o, f, c);
         return;
      end
      step(1'b0, 1'($urandom), o, f, c);

      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i <= w; i++) begin
            c = zc(3'd3);
            {c.alu_op, c.alu_src, c.ext_zero} = alu_of(k, f);
            c.mem_read = (k == K_LW);
            c.mem_write = (k == K_SW);
            if (!abort && k == K_SW && i == w) begin
               c.pc_write = 1'b1;
               c.retire = 1'b1;
            end
            step(1'b0, (!abort && i == w), o, f, c);
         end
         if (abort) begin
            step(1'b1, 1'($urandom), o, f, zc(3'd0));
            return;
         end
         if (k == K_SW) return;
      end

      c = zc(3'd4);
      {c.alu_op, c.alu_src, c.ext_zero} = alu_of(k, f);
      c.reg_write = 1'b1;
      c.reg_dst = (k == K_R);
      c.mem_to_reg = (k == K_LW);
      c.pc_write = 1'b1;
      c.retire = 1'b1;
      step(1'b0, 1'($urandom), o, f, c);
   endtask

   // Monitor: compare the DUT against the next queued expectation each cycle.
   initial begin
      exp_t e;
      ctl_t act;
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            act = {state, ir_write, pc_write, npc_op, reg_write, reg_dst, alu_src,
                   ext_zero, alu_op, mem_read, mem_write, mem_to_reg, illegal, retire};
            checks++;
            if (act !== e.c) begin
               failures++;
               $display("FAIL ctl cycle=%0d got=%h exp=%h (st got %0d exp %0d)",
                        cyc, act, e.c, act.st, e.c.st);
            end
            checks++;
            if (retired_cnt !== e.cnt) begin
               failures++;
               $display("FAIL retired_cnt cycle=%0d got=%0d exp=%0d", cyc, retired_cnt, e.cnt);
            end
            checks++;
            if (retired_cnt_s !== e.cnt[3:0]) begin
               failures++;
               $display("FAIL retired_cnt_wrap cycle=%0d got=%0d exp=%0d",
                        cyc, retired_cnt_s, e.cnt[3:0]);
            end
         end
      end
   end

   // Stimulus: reset, directed cases, mid-lw reset, then random instructions.
   initial begin
      logic [5:0] rf[5];
      int         pick;
      logic [5:0] o, f;
      rf[0] = 6'h20; rf[1] = 6'h22; rf[2] = 6'h24; rf[3] = 6'h25; rf[4] = 6'h2a;

      reset_cycles(3);
      run_inst(6'h00, 6'h20, 0, 1'b0);      // add
      run_inst(6'h23, 6'h00, 2, 1'b1);      // lw aborted by reset in S_MEM
      run_inst(6'h00, 6'h20, 0, 1'b0);      // add
      run_inst(6'h04, 6'h11, 0, 1'b0);      // beq
      run_inst(6'h05, 6'h02, 0, 1'b0);      // bne
      run_inst(6'h23, 6'h00, 3, 1'b0);      // lw, 3 wait cycles
      run_inst(6'h02, 6'h00, 0, 1'b0);      // j
      run_inst(6'h00, 6'h08, 0, 1'b0);      // jr
      run_inst(6'h3f, 6'h15, 0, 1'b0);      // illegal opcode
      run_inst(6'h00, 6'h3f, 0, 1'b0);      // illegal funct
      run_inst(6'h2b, 6'h00, 2, 1'b0);      // sw
      run_inst(6'h2b, 6'h00, 0, 1'b0);      // sw, no wait
      run_inst(6'h08, 6'h00, 0, 1'b0);      // addi
      run_inst(6'h0d, 6'h00, 0, 1'b0);      // ori
      run_inst(6'h00, 6'h2a, 0, 1'b0);      // slt

      for (int n = 0; n < 300; n++) begin
         pick = int'($urandom_range(0, 12));
         f = 6'($urandom);
         case (pick)
            0:  begin o = 6'h00; f = rf[$urandom_range(0, 4)]; end
            1:  begin o = 6'h00; f = 6'h08; end
            2:  o = 6'h02;
            3:  o = 6'h23;
            4:  o = 6'h2b;
            5:  o = 6'h04;
            6:  o = 6'h05;
            7:  o = 6'h08;
            8:  o = 6'h0d;
            9:  begin o = 6'h23; end
            10: begin o = 6'h2b; end
            default: o = 6'($urandom);
         endcase
         run_inst(o, f, int'($urandom_range(0, 3)), 1'b0);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
